// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage access controller: size selectors, FSM states and
// the timeout counter width helper.
package mem_access_ctrl_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_WORD = 2'b00;
  localparam sel_t SEL_BYTE = 2'b01;
  localparam sel_t SEL_HALF = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_align.sv
// Combinational byte-lane logic: alignment check, byte enables, store-data lane shift and
// load-data extraction with sign/zero extension.
module byte_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned NBITS = 32
) (
  input  logic [1:0]       off_i,
  input  sel_t             sel_i,
  input  logic [NBITS-1:0] wdata_i,
  output logic             legal_o,
  output logic [3:0]       be_o,
  output logic [NBITS-1:0] wdata_o,
  input  logic [1:0]       rd_off_i,
  input  sel_t             rd_sel_i,
  input  logic             rd_unsigned_i,
  input  logic [NBITS-1:0] rdata_i,
  output logic [NBITS-1:0] rdata_o
);

  logic [NBITS-1:0] rd_shifted;
  logic             ext_bit;

  always_comb begin
    legal_o = 1'b0;
    be_o    = 4'b0000;
    case (sel_i)
      SEL_WORD: begin
        legal_o = (off_i == 2'b00);
        be_o    = 4'b1111;
      end
      SEL_HALF: begin
        legal_o = ~off_i[0];
        be_o    = 4'b0011 << off_i;
      end
      SEL_BYTE: begin
        legal_o = 1'b1;
        be_o    = 4'b0001 << off_i;
      end
      default: begin
        legal_o = 1'b0;
        be_o    = 4'b0000;
      end
    endcase
  end

  assign wdata_o = wdata_i << {off_i, 3'b000};

  assign rd_shifted = rdata_i >> {rd_off_i, 3'b000};

  always_comb begin
    ext_bit = 1'b0;
    rdata_o = rd_shifted;
    case (rd_sel_i)
      SEL_BYTE: begin
        ext_bit = ~rd_unsigned_i & rd_shifted[7];
        rdata_o = {{(NBITS - 8){ext_bit}}, rd_shifted[7:0]};
      end
      SEL_HALF: begin
        ext_bit = ~rd_unsigned_i & rd_shifted[15];
        rdata_o = {{(NBITS - 16){ext_bit}}, rd_shifted[15:0]};
      end
      default: rdata_o = rd_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: accepts one request, checks alignment, drives a req/ack
// data-memory port with a watchdog, and returns extended load data with a done pulse.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned TNBITS  = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_mem_write,
  input  logic              i_mem_read,
  input  logic [NBITS-1:0]  i_addr,
  input  logic [NBITS-1:0]  i_wdata,
  input  logic [TNBITS-1:0] i_selector,
  input  logic              i_unsigned,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [NBITS-1:0]  o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [NBITS-1:0]  o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [NBITS-1:0]  i_mem_rdata,
  output logic              o_done,
  output logic [NBITS-1:0]  o_rdata,
  output logic              o_misaligned,
  output logic              o_bus_error
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic [NBITS-1:0] rdata_q, rdata_d;
  logic [3:0]       be_q, be_d;
  logic             we_q, we_d;
  sel_t             sel_q, sel_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic             misaligned_q, misaligned_d;
  logic             bus_error_q, bus_error_d;

  logic             legal;
  logic [3:0]       be_new;
  logic [NBITS-1:0] wdata_new;
  logic [NBITS-1:0] rdata_ext;
  logic             accept;

  byte_lane_align #(
    .NBITS(NBITS)
  ) u_align (
    .off_i        (i_addr[1:0]),
    .sel_i        (i_selector),
    .wdata_i      (i_wdata),
    .legal_o      (legal),
    .be_o         (be_new),
    .wdata_o      (wdata_new),
    .rd_off_i     (off_q),
    .rd_sel_i     (sel_q),
    .rd_unsigned_i(uns_q),
    .rdata_i      (i_mem_rdata),
    .rdata_o      (rdata_ext)
  );

  assign accept = (state_q == IDLE) & i_valid & (i_mem_read | i_mem_write);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    be_d         = be_q;
    we_d         = we_q;
    sel_d        = sel_q;
    uns_d        = uns_q;
    off_d        = off_q;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            addr_d  = {i_addr[NBITS-1:2], 2'b00};
            wdata_d = wdata_new;
            be_d    = be_new;
            we_d    = i_mem_write;
            sel_d   = i_selector;
            uns_d   = i_unsigned;
            off_d   = i_addr[1:0];
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            misaligned_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (i_mem_ack) begin
          // Stores leave the previous load result in place.
          if (!we_q) begin
            rdata_d = rdata_ext;
          end
          cnt_d   = '0;
          state_d = RESP;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          bus_error_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      sel_q        <= SEL_WORD;
      uns_q        <= 1'b0;
      off_q        <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign o_ready      = (state_q == IDLE);
  assign o_mem_req    = (state_q == ACCESS);
  assign o_mem_we     = o_mem_req & we_q;
  assign o_mem_be     = o_mem_req ? be_q : 4'b0000;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_done       = (state_q == RESP);
  assign o_rdata      = rdata_q;
  assign o_misaligned = misaligned_q;
  assign o_bus_error  = bus_error_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized transactions
// against an arithmetic reference model of the access rules.
module tb_mem_access_ctrl;

  localparam int unsigned NBITS   = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid;
  logic              ready;
  logic              mem_write;
  logic              mem_read;
  logic [NBITS-1:0]  addr;
  logic [NBITS-1:0]  wdata;
  logic [1:0]        selector;
  logic              uns;
  logic              mem_req;
  logic              mem_we;
  logic [NBITS-1:0]  mem_addr;
  logic [3:0]        mem_be;
  logic [NBITS-1:0]  mem_wdata;
  logic              mem_ack;
  logic [NBITS-1:0]  mem_rdata;
  logic              done;
  logic [NBITS-1:0]  rdata;
  logic              misaligned;
  logic              bus_error;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .NBITS  (NBITS),
    .TNBITS (2),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_mem_write (mem_write),
    .i_mem_read  (mem_read),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_selector  (selector),
    .i_unsigned  (uns),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_be    (mem_be),
    .o_mem_wdata (mem_wdata),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata),
    .o_done      (done),
    .o_rdata     (rdata),
    .o_misaligned(misaligned),
    .o_bus_error (bus_error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_bytes(input logic [1:0] sel);
    case (sel)
      2'b00:   return 4;
      2'b10:   return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit model_legal(input logic [1:0] sel, input logic [31:0] a);
    case (sel)
      2'b00:   return (a % 4) == 0;
      2'b10:   return (a % 2) == 0;
      2'b01:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sel, input logic [31:0] a);
    int n;
    n = size_bytes(sel);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [31:0] a);
    longint unsigned v;
    v = longint'(d) * (longint'(1) << (8 * (a % 4)));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sel, input logic [31:0] a,
                                             input bit u, input logic [31:0] word);
    longint unsigned v, span;
    int n;
    n    = size_bytes(sel);
    span = longint'(1) << (8 * n);
    v    = (longint'(word) >> (8 * (a % 4))) % span;
    if (!u && n < 4 && v >= span / 2) v = v + ((longint'(1) << 32) - span);
    return v[31:0];
  endfunction

  // delay = number of ACCESS cycles without ack before the ack; >= TIMEOUT means none.
  task automatic do_txn(input string nm, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sel, input bit u,
                        input int delay, input logic [31:0] word);
    bit is_load;
    is_load = rd && !wr;
    check({nm, ".ready_pre"}, 32'(ready), 32'd1);
    valid = 1'b1; mem_write = wr; mem_read = rd; addr = a; wdata = d;
    selector = sel; uns = u;
    step();
    valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    addr = $urandom; wdata = $urandom; selector = 2'($urandom); uns = 1'($urandom);
    if (!model_legal(sel, a)) begin
      check({nm, ".misaligned"}, 32'(misaligned), 32'd1);
      check({nm, ".mis_req"}, 32'(mem_req), 32'd0);
      check({nm, ".mis_ready"}, 32'(ready), 32'd1);
      step();
      check({nm, ".mis_pulse"}, 32'(misaligned), 32'd0);
      check({nm, ".mis_req2"}, 32'(mem_req), 32'd0);
      return;
    end
    check({nm, ".no_mis"}, 32'(misaligned), 32'd0);
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      check({nm, ".req"}, 32'(mem_req), 32'd1);
      check({nm, ".ready_busy"}, 32'(ready), 32'd0);
      if (k == 1) begin
        check({nm, ".addr"}, mem_addr, {a[31:2], 2'b00});
        check({nm, ".be"}, 32'(mem_be), 32'(model_be(sel, a)));
        check({nm, ".we"}, 32'(mem_we), 32'(wr));
        check({nm, ".wdata"}, mem_wdata, model_wdata(d, a));
      end
      if (k == delay + 1) begin
        mem_ack = 1'b1; mem_rdata = word;
        step();
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (is_load) exp_rdata = model_load(sel, a, u, word);
        check({nm, ".done"}, 32'(done), 32'd1);
        check({nm, ".resp_req"}, 32'(mem_req), 32'd0);
        check({nm, ".resp_ready"}, 32'(ready), 32'd0);
        check({nm, ".no_buserr"}, 32'(bus_error), 32'd0);
        if (is_load) check({nm, ".rdata"}, rdata, exp_rdata);
        step();
        check({nm, ".done_pulse"}, 32'(done), 32'd0);
        check({nm, ".ready_post"}, 32'(ready), 32'd1);
        return;
      end
      step();
    end
    check({nm, ".bus_error"}, 32'(bus_error), 32'd1);
    check({nm, ".to_done"}, 32'(done), 32'd0);
    check({nm, ".to_req"}, 32'(mem_req), 32'd0);
    check({nm, ".to_ready"}, 32'(ready), 32'd1);
    step();
    check({nm, ".buserr_pulse"}, 32'(bus_error), 32'd0);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    addr = '0; wdata = '0; selector = 2'b00; uns = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    reset = 1'b0;
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.req", 32'(mem_req), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.rdata", rdata, 32'h0);
    check("rst.mis", 32'(misaligned), 32'd0);
    check("rst.buserr", 32'(bus_error), 32'd0);
    check("rst.be", 32'(mem_be), 32'd0);
    check("rst.we", 32'(mem_we), 32'd0);

    do_txn("sb", 1, 0, 32'h1002, 32'h000000AB, 2'b01, 0, 0, 32'h0);
    do_txn("lh", 0, 1, 32'h2002, 32'h0, 2'b10, 0, 3, 32'h80011234);
    do_txn("lbu", 0, 1, 32'h0003, 32'h0, 2'b01, 1, 1, 32'h80FFFFFF);
    do_txn("lb", 0, 1, 32'h0003, 32'h0, 2'b01, 0, 1, 32'h80FFFFFF);
    do_txn("sh_mis", 1, 0, 32'h1001, 32'h1234, 2'b10, 0, 0, 32'h0);
    do_txn("lw_mis", 0, 1, 32'h2002, 32'h0, 2'b00, 0, 0, 32'h0);
    do_txn("sel11", 0, 1, 32'h3000, 32'h0, 2'b11, 0, 0, 32'h0);
    do_txn("rw_both", 1, 1, 32'h0040, 32'hCAFEF00D, 2'b00, 0, 2, 32'h0);
    do_txn("lw", 0, 1, 32'h0044, 32'h0, 2'b00, 0, 0, 32'hDEADBEEF);
    do_txn("tmo", 0, 1, 32'h0048, 32'h0, 2'b00, 0, TIMEOUT, 32'h0);
    do_txn("ack16", 0, 1, 32'h004C, 32'h0, 2'b10, 1, TIMEOUT - 1, 32'h0000F00F);

    // Request with neither read nor write is ignored.
    valid = 1'b1;
    step();
    valid = 1'b0;
    check("nop.ready", 32'(ready), 32'd1);
    check("nop.req", 32'(mem_req), 32'd0);
    check("nop.mis", 32'(misaligned), 32'd0);

    // Ack outside ACCESS is ignored.
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    check("idle_ack.done", 32'(done), 32'd0);
    check("idle_ack.rdata", rdata, exp_rdata);

    // Reset during the second ACCESS cycle.
    valid = 1'b1; mem_read = 1'b1; addr = 32'h0080; selector = 2'b00; uns = 1'b0;
    step();
    valid = 1'b0; mem_read = 1'b0;
    check("mrst.req1", 32'(mem_req), 32'd1);
    step();
    check("mrst.req2", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_rdata = 32'h0;
    check("mrst.req", 32'(mem_req), 32'd0);
    check("mrst.ready", 32'(ready), 32'd1);
    check("mrst.done", 32'(done), 32'd0);
    check("mrst.rdata", rdata, 32'h0);
    step();
    check("mrst.done2", 32'(done), 32'd0);
    do_txn("sw_after", 1, 0, 32'h0010, 32'h55AA33CC, 2'b00, 0, 0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      bit wr_r, rd_r;
      wr_r = 1'($urandom);
      rd_r = wr_r ? 1'($urandom) : 1'b1;
      do_txn("rnd", wr_r, rd_r, $urandom, $urandom, 2'($urandom), 1'($urandom),
             int'($urandom_range(0, TIMEOUT + 1)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
